iter_shifter: RTL

Multi-cycle, parametrised shift unit for the MIPS datapath. It replaces the fixed left-shift-by-2 wiring with a general SLL/SRL/SRA engine that takes a variable shift amount. The shift is performed STEP bit positions per clock under a start/busy/done handshake. It sits beside the ALU and serves the shift instructions (sll, srl, sra, sllv, srlv, srav); the branch-offset path can also use it with shamt=2.

---
 rtl/iter_shifter.sv | 88 ++++++++
 1 files changed

// File: rtl/iter_shifter.sv
// Iterative SLL/SRL/SRA shifter (ROTR on op=11 when SHIFTER_ROTATE_EN is defined, else op=11 is SLL).
// Latency ceil(shamt/STEP)+1 cycles from start to done; start is ignored while busy, no queuing.
module iter_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   din,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROTR = 2'b11} op_t;

   // Only used when rem exceeds STEP, so truncation for large STEP never matters.
   localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

   state_t             state;
   op_t                op_q;
   logic [SHAMT_W-1:0] rem;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] n;
   logic [WIDTH-1:0]   acc_nxt;

   always_comb begin
      n = rem;
      if (32'(rem) > 32'(STEP)) n = STEP_N;
   end

   // SRA keeps the sign in acc's MSB, so each arithmetic step re-replicates the original din MSB.
   always_comb begin
      acc_nxt = acc << n;
      case (op_q)
         OP_SRL:  acc_nxt = acc >> n;
         OP_SRA:  acc_nxt = $signed(acc) >>> n;
`ifdef SHIFTER_ROTATE_EN
         OP_ROTR: acc_nxt = (acc >> n) | (acc << (WIDTH - 32'(n)));
`endif
         default: acc_nxt = acc << n;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op_q  <= OP_SLL;
         rem   <= '0;
         acc   <= '0;
         dout  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_RUN) begin
            acc <= acc_nxt;
            rem <= rem - n;
            if (rem == n) begin
               dout  <= acc_nxt;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_DONE;
            end
         end else if (start) begin
            op_q <= op_t'(op);
            acc  <= din;
            rem  <= shamt;
            if (shamt == '0) begin
               dout  <= din;
               done  <= 1'b1;
               state <= S_DONE;
            end else begin
               busy  <= 1'b1;
               state <= S_RUN;
            end
         end else begin
            state <= S_IDLE;
         end
      end
   end

endmodule
